// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types, constants and pitch-table helper for the oscillator bank
package synth_pkg;

   localparam int NOTE_W = 7;
   localparam longint unsigned CLK_HZ = 64'd50_000_000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MATCH,
      ST_COMMIT
   } fsm_state_e;

   typedef logic [11:0][23:0] semi_tab_t;

   // Octave-10 pitches (MIDI 120..131, C9..B9) in millihertz.
   localparam longint unsigned OCT10_MHZ [12] = '{
      64'd8372018,  64'd8869844,  64'd9397273,  64'd9956063,
      64'd10548082, 64'd11175303, 64'd11839822, 64'd12543854,
      64'd13289750, 64'd14080000, 64'd14917240, 64'd15804266
   };

   // Phase increment per sample tick for each octave-10 semitone.
   function automatic semi_tab_t semi_inc_table(input int acc_w, input int presc);
      semi_tab_t tab;
      tab = '0;
      for (int s = 0; s < 12; s++) begin
         tab[s] = 24'((OCT10_MHZ[s] * (64'd1 << acc_w) * 64'(presc)) / (CLK_HZ * 64'd1000));
      end
      return tab;
   endfunction

endpackage

// File: rtl/voice_lru.sv
// rtl/voice_lru.sv - least-recently-allocated ranking of the oscillator voices
module voice_lru
   import synth_pkg::*;
#(
   parameter int VOICES = 6
) (
   input  logic                      clk_i,
   input  logic                      nrst_i,
   input  logic                      alloc_i,
   input  logic [$clog2(VOICES)-1:0] alloc_idx_i,
   output logic [$clog2(VOICES)-1:0] oldest_o
);

   localparam int IDX_W = $clog2(VOICES);

   logic [VOICES-1:0][IDX_W-1:0] rank_q, rank_d;

   // Rank 0 is the newest allocation; everything younger than the chosen voice ages by one.
   always_comb begin
      rank_d = rank_q;
      if (alloc_i) begin
         for (int v = 0; v < VOICES; v++) begin
            if (rank_q[v] < rank_q[alloc_idx_i]) begin
               rank_d[v] = rank_q[v] + 1'b1;
            end
         end
         rank_d[alloc_idx_i] = '0;
      end
   end

   always_comb begin
      oldest_o = '0;
      for (int v = 0; v < VOICES; v++) begin
         if (rank_q[v] == IDX_W'(VOICES - 1)) begin
            oldest_o = IDX_W'(v);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         for (int v = 0; v < VOICES; v++) begin
            rank_q[v] <= IDX_W'(v);
         end
      end else begin
         rank_q <= rank_d;
      end
   end

endmodule

// File: rtl/poly_osc_bank.sv
// rtl/poly_osc_bank.sv - polyphonic square-wave oscillator bank with voice allocation and activity PWM
module poly_osc_bank
   import synth_pkg::*;
#(
   parameter int VOICES = 6,
   parameter int ACC_W  = 16,
   parameter int PRESC  = 64
) (
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic              evValid_i,
   output logic              evReady_o,
   input  logic              evNoteOn_i,
   input  logic [NOTE_W-1:0] evNote_i,
   output logic [VOICES-1:0] oscOut_o,
   output logic              activeOscPwm_o
);

   localparam int IDX_W = $clog2(VOICES);
   localparam int CNT_W = $clog2(PRESC);
   localparam int POP_W = $clog2(VOICES + 1);
   localparam semi_tab_t SEMI_INC = semi_inc_table(ACC_W, PRESC);

   fsm_state_e                    state_q, state_d;
   logic                          ready_q, ready_d;
   logic                          ev_on_q, ev_on_d;
   logic [NOTE_W-1:0]             ev_note_q, ev_note_d;
   logic                          sel_vld_q, sel_vld_d;
   logic [IDX_W-1:0]              sel_idx_q, sel_idx_d;
   logic [VOICES-1:0]             active_q, active_d;
   logic [VOICES-1:0][NOTE_W-1:0] note_q, note_d;
   logic [VOICES-1:0][ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]              tick_cnt_q, tick_cnt_d;
   logic [IDX_W-1:0]              pwm_cnt_q, pwm_cnt_d;
   logic                          pwm_q, pwm_d;
   logic                          tick, commit, hit, free;
   logic [IDX_W-1:0]              hit_idx, free_idx, oldest_idx;
   logic [POP_W-1:0]              act_cnt;

   function automatic logic [ACC_W-1:0] note_inc(input logic [NOTE_W-1:0] note);
      logic [3:0] oct;
      logic [3:0] semi;
      oct  = 4'(note / 7'd12);
      semi = 4'(note % 7'd12);
      return ACC_W'(SEMI_INC[semi] >> (4'd10 - oct));
   endfunction

   voice_lru #(.VOICES(VOICES)) u_lru (
      .clk_i       (clk_i),
      .nrst_i      (nrst_i),
      .alloc_i     (commit & sel_vld_q & ev_on_q),
      .alloc_idx_i (sel_idx_q),
      .oldest_o    (oldest_idx)
   );

   // Descending scan leaves the lowest-index match in each result.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int v = VOICES - 1; v >= 0; v--) begin
         if (active_q[v] && (note_q[v] == ev_note_q)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(v);
         end
         if (!active_q[v]) begin
            free     = 1'b1;
            free_idx = IDX_W'(v);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ev_on_d   = ev_on_q;
      ev_note_d = ev_note_q;
      sel_vld_d = sel_vld_q;
      sel_idx_d = sel_idx_q;
      commit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (evValid_i && ready_q) begin
               ev_on_d   = evNoteOn_i;
               ev_note_d = evNote_i;
               state_d   = ST_MATCH;
            end
         end
         ST_MATCH: begin
            sel_vld_d = ev_on_q | hit;
            if (hit) begin
               sel_idx_d = hit_idx;
            end else if (free) begin
               sel_idx_d = free_idx;
            end else begin
               sel_idx_d = oldest_idx;
            end
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            commit  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   assign tick = (tick_cnt_q == CNT_W'(PRESC - 1));

   // The commit is applied after the tick so a same-cycle allocation leaves acc at zero.
   always_comb begin
      active_d   = active_q;
      note_d     = note_q;
      acc_d      = acc_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      for (int v = 0; v < VOICES; v++) begin
         if (tick && active_q[v]) begin
            acc_d[v] = acc_q[v] + note_inc(note_q[v]);
         end
         if (commit && sel_vld_q && (sel_idx_q == IDX_W'(v))) begin
            active_d[v] = ev_on_q;
            if (ev_on_q) begin
               note_d[v] = ev_note_q;
               acc_d[v]  = '0;
            end
         end
      end
   end

   always_comb begin
      act_cnt = '0;
      for (int v = 0; v < VOICES; v++) begin
         act_cnt = act_cnt + POP_W'(active_q[v]);
      end
      pwm_cnt_d = (pwm_cnt_q == IDX_W'(VOICES - 1)) ? '0 : pwm_cnt_q + 1'b1;
      pwm_d     = (POP_W'(pwm_cnt_q) < act_cnt);
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         ev_on_q    <= 1'b0;
         ev_note_q  <= '0;
         sel_vld_q  <= 1'b0;
         sel_idx_q  <= '0;
         active_q   <= '0;
         note_q     <= '0;
         acc_q      <= '0;
         tick_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         pwm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         ev_on_q    <= ev_on_d;
         ev_note_q  <= ev_note_d;
         sel_vld_q  <= sel_vld_d;
         sel_idx_q  <= sel_idx_d;
         active_q   <= active_d;
         note_q     <= note_d;
         acc_q      <= acc_d;
         tick_cnt_q <= tick_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         pwm_q      <= pwm_d;
      end
   end

   always_comb begin
      oscOut_o = '0;
      for (int v = 0; v < VOICES; v++) begin
         oscOut_o[v] = active_q[v] & acc_q[v][ACC_W-1];
      end
   end

   assign evReady_o      = ready_q;
   assign activeOscPwm_o = pwm_q;

endmodule

// File: tb/tb_poly_osc_bank.sv
// tb/tb_poly_osc_bank.sv - scoreboard bench for poly_osc_bank
module tb_poly_osc_bank;

   localparam int VOICES = 6;
   localparam int ACC_W  = 16;
   localparam int PRESC  = 64;

   logic              clk = 1'b0;
   logic              nrst_i = 1'b0;
   logic              evValid_i = 1'b0;
   logic              evNoteOn_i = 1'b0;
   logic [6:0]        evNote_i = '0;
   logic              evReady_o;
   logic [VOICES-1:0] oscOut_o;
   logic              activeOscPwm_o;

   always #5 clk = ~clk;

   poly_osc_bank #(.VOICES(VOICES), .ACC_W(ACC_W), .PRESC(PRESC)) dut (
      .clk_i          (clk),
      .nrst_i         (nrst_i),
      .evValid_i      (evValid_i),
      .evReady_o      (evReady_o),
      .evNoteOn_i     (evNoteOn_i),
      .evNote_i       (evNote_i),
      .oscOut_o       (oscOut_o),
      .activeOscPwm_o (activeOscPwm_o)
   );

   typedef struct {
      logic              on;
      logic [6:0]        note;
      int                idx;
      logic [VOICES-1:0] mask;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic send_ev(input logic on, input logic [6:0] note, input int idx,
                          input logic [VOICES-1:0] mask);
      int guard;
      guard = 0;
      while (!evReady_o && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!evReady_o) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout actual=0 required=1");
         return;
      end
      sb_q.push_back('{on, note, idx, mask});
      evValid_i  = 1'b1;
      evNoteOn_i = on;
      evNote_i   = note;
      @(posedge clk); #1;
      evValid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      int   phase;
      exp_t e;
      phase = 0;
      forever begin
         @(negedge clk);
         if (phase == 1 || phase == 2) begin
            check("ready_low", evReady_o, 0);
            phase++;
         end else if (phase == 3) begin
            check("ready_back", evReady_o, 1);
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_empty actual=0 required=1");
            end else begin
               e = sb_q.pop_front();
               check($sformatf("active_mask_note%0d", e.note), dut.active_q, e.mask);
               check($sformatf("idle_osc_note%0d", e.note), oscOut_o & ~e.mask, 0);
               if (e.idx >= 0) begin
                  if (e.on) begin
                     check($sformatf("voice_note_v%0d", e.idx), dut.note_q[e.idx], e.note);
                     check($sformatf("voice_acc_v%0d", e.idx), dut.acc_q[e.idx], 0);
                  end
                  check($sformatf("voice_osc_v%0d", e.idx), oscOut_o[e.idx], 0);
               end
            end
            phase = 0;
         end
         if (phase == 0 && evValid_i && evReady_o && nrst_i) begin
            phase = 1;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int hi;
      int guard;
      logic [ACC_W-1:0] a0, a1, a2, d;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", evReady_o, 0);
      check("rst_osc", oscOut_o, 0);
      check("rst_pwm", activeOscPwm_o, 0);
      check("rst_active", dut.active_q, 0);
      nrst_i = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", evReady_o, 1);
      hi = 0;
      repeat (12) begin
         @(posedge clk); #1;
         hi += int'(activeOscPwm_o);
      end
      check("pwm_idle", hi, 0);

      // single note: inc(69) = 1181 >> 5 = 36, inc(81) = 1181 >> 4 = 73
      send_ev(1'b1, 7'd69, 0, 6'b000001);
      a0 = dut.acc_q[0];
      repeat (640) @(posedge clk);
      #1;
      d = dut.acc_q[0] - a0;
      check("inc_note69", d, 360);
      send_ev(1'b1, 7'd81, 1, 6'b000011);
      a0 = dut.acc_q[0];
      a1 = dut.acc_q[1];
      repeat (640) @(posedge clk);
      #1;
      d = dut.acc_q[1] - a1;
      check("inc_note81", d, 730);
      d = dut.acc_q[0] - a0;
      check("inc_note69_again", d, 360);
      send_ev(1'b0, 7'd69, 0, 6'b000010);
      send_ev(1'b0, 7'd81, 1, 6'b000000);

      // retrigger and note-off
      send_ev(1'b1, 7'd60, 0, 6'b000001);
      send_ev(1'b1, 7'd64, 1, 6'b000011);
      repeat (300) @(posedge clk);
      #1;
      check("pre_retrig_acc_nonzero", dut.acc_q[0] != '0, 1);
      send_ev(1'b1, 7'd60, 0, 6'b000011);
      send_ev(1'b0, 7'd64, 1, 6'b000001);
      send_ev(1'b0, 7'd99, -1, 6'b000001);

      // steal
      send_ev(1'b0, 7'd60, 0, 6'b000000);
      for (int i = 0; i < VOICES; i++) begin
         send_ev(1'b1, 7'(60 + i), i, VOICES'((1 << (i + 1)) - 1));
      end
      send_ev(1'b1, 7'd70, 0, 6'b111111);
      send_ev(1'b1, 7'd71, 1, 6'b111111);

      // free voice reuse: oldest is voice 2, free is voice 4
      send_ev(1'b0, 7'd64, 4, 6'b101111);
      send_ev(1'b1, 7'd80, 4, 6'b111111);

      // pwm with three active voices (2, 3, 5)
      send_ev(1'b0, 7'd70, 0, 6'b111110);
      send_ev(1'b0, 7'd71, 1, 6'b111100);
      send_ev(1'b0, 7'd80, 4, 6'b101100);
      repeat (2) @(posedge clk);
      #1;
      hi = 0;
      repeat (60) begin
         @(posedge clk); #1;
         hi += int'(activeOscPwm_o);
      end
      check("pwm_3_of_6", hi, 30);

      // commit coincides with tick; voice 2 (note 62, inc 788 >> 5 = 24) still advances
      guard = 0;
      while (dut.tick_cnt_q != 6'd61 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("tick_align", dut.tick_cnt_q, 61);
      a2 = dut.acc_q[2];
      send_ev(1'b1, 7'd90, 0, 6'b101101);
      d = dut.acc_q[2] - a2;
      check("collision_other_voice", d, 24);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb_q.size(), 0);

      nrst_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst2_ready", evReady_o, 0);
      check("rst2_active", dut.active_q, 0);
      check("rst2_osc", oscOut_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
